// File: rtl/zxw_panel_pkg.sv
// Shared constants for the front panel: segment table, digit-enable codes and parameter defaults.
package zxw_panel_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned SCAN_DIV_DEF        = 4;
  localparam int unsigned CNT_W               = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_LOW    = 2'b10;
  localparam logic [1:0] AN_HIGH   = 2'b01;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // Active-low {g,f,e,d,c,b,a}, listed from code F down to code 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/zxw_front_panel_v_debounce.sv
// One-bit input conditioner: two-flop synchronizer followed by a stability counter.
module zxw_debounce_v
  import zxw_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_i,
  output logic stable_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized level disagrees with the stable level
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/zxw_front_panel_v.sv
// Front panel: debounced switches, pushbutton press pulses and a two-digit multiplexed hex display.
module zxw_front_panel_v
  import zxw_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] SW_raw,
  input  logic [3:0] PB_raw,
  input  logic [3:0] DHR_in,
  input  logic [3:0] DLR_in,
  output logic [3:0] SW_out,
  output logic [3:0] PB_out,
  output logic [6:0] Seg_out,
  output logic [1:0] AN_out
);

  logic [7:0] raw_all;
  logic [7:0] stable_all;
  logic [3:0] pb_stable;

  assign raw_all = {PB_raw, SW_raw};

  for (genvar i = 0; i < 8; i++) begin : g_deb
    zxw_debounce_v #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .Clock   (Clock),
      .Reset   (Reset),
      .raw_i   (raw_all[i]),
      .stable_o(stable_all[i])
    );
  end

  assign SW_out    = stable_all[3:0];
  assign pb_stable = stable_all[7:4];

  logic [3:0]       pb_prev_q, pb_prev_d;
  logic [3:0]       pb_out_q, pb_out_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             digit_sel_q, digit_sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  always_comb begin
    pb_prev_d   = pb_stable;
    pb_out_d    = pb_stable & ~pb_prev_q;
    scan_cnt_d  = scan_cnt_q + CNT_W'(1);
    digit_sel_d = digit_sel_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d  = '0;
      digit_sel_d = ~digit_sel_q;
    end
    // Display output is built from the current digit select, so it lags by one cycle
    an_d  = digit_sel_q ? AN_HIGH : AN_LOW;
    seg_d = hex_to_seg(digit_sel_q ? DHR_in : DLR_in);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pb_prev_q   <= '0;
      pb_out_q    <= '0;
      scan_cnt_q  <= '0;
      digit_sel_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
    end else begin
      pb_prev_q   <= pb_prev_d;
      pb_out_q    <= pb_out_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign PB_out  = pb_out_q;
  assign Seg_out = seg_q;
  assign AN_out  = an_q;

endmodule

// File: tb/tb_zxw_front_panel_v.sv
// Self-checking bench for zxw_front_panel_v: scoreboarded switch/button timing plus per-cycle display checks.
module tb_zxw_front_panel_v;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] SW_raw, PB_raw, DHR_in, DLR_in;
  logic [3:0] SW_out, PB_out;
  logic [6:0] Seg_out;
  logic [1:0] AN_out;

  always #5 Clock = ~Clock;

  zxw_front_panel_v #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_DIV       (4)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .SW_raw (SW_raw),
    .PB_raw (PB_raw),
    .DHR_in (DHR_in),
    .DLR_in (DLR_in),
    .SW_out (SW_out),
    .PB_out (PB_out),
    .Seg_out(Seg_out),
    .AN_out (AN_out)
  );

  typedef struct {
    int         due;
    logic [3:0] sw;
    logic [3:0] pb;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] dhr;
    logic [3:0] dlr;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;
  } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         rel    = 0;
  logic [3:0] sw_lvl = 4'h0;
  logic [6:0] exp_lo = 7'h79;
  logic [6:0] exp_hi = 7'h08;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int dly, input logic [3:0] sw, input logic [3:0] pb, input string name);
    sbq.push_back('{cyc + dly, sw, pb, name});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: samples 1 time unit after each rising edge; inputs only change on falling edges
  initial begin
    logic [1:0] exp_an;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (Reset) begin
        rel = 0;
        chk("rst_seg", 32'(Seg_out), 32'h7F);
        chk("rst_an",  32'(AN_out),  32'h3);
        chk("rst_sw",  32'(SW_out),  32'h0);
        chk("rst_pb",  32'(PB_out),  32'h0);
      end else begin
        rel++;
        exp_an = ((((rel - 1) / 4) % 2) == 0) ? 2'b10 : 2'b01;
        chk("an", 32'(AN_out), 32'(exp_an));
        chk("seg", 32'(Seg_out), 32'((exp_an == 2'b10) ? exp_lo : exp_hi));
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed due=%0d now=%0d", sbq[0].name, sbq[0].due, cyc);
          void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          chk({sbq[0].name, "_sw"}, 32'(SW_out), 32'(sbq[0].sw));
          chk({sbq[0].name, "_pb"}, 32'(PB_out), 32'(sbq[0].pb));
          void'(sbq.pop_front());
        end else begin
          chk("pb_idle", 32'(PB_out), 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] old_sw;
    Reset  = 1'b1;
    SW_raw = 4'hF;
    PB_raw = 4'h0;
    DHR_in = 4'hA;
    DLR_in = 4'h1;

    vecs[0] = '{4'b0101, 4'h0, 4'h1, 7'h79, 7'h40};
    vecs[1] = '{4'b1111, 4'h2, 4'h3, 7'h30, 7'h24};
    vecs[2] = '{4'b0000, 4'h4, 4'h5, 7'h12, 7'h19};
    vecs[3] = '{4'b1001, 4'h6, 4'h7, 7'h78, 7'h02};
    vecs[4] = '{4'b0110, 4'h8, 4'h9, 7'h10, 7'h00};
    vecs[5] = '{4'b0110, 4'hA, 4'hB, 7'h03, 7'h08};
    vecs[6] = '{4'b1100, 4'hC, 4'hD, 7'h21, 7'h46};
    vecs[7] = '{4'b0011, 4'hE, 4'hF, 7'h0E, 7'h06};

    tick(3);

    // Release reset and apply a steady switch pattern
    Reset  = 1'b0;
    SW_raw = 4'b1010;
    push(5, 4'h0, 4'h0, "sw_pre");
    push(6, 4'b1010, 4'h0, "sw_1010");
    sw_lvl = 4'b1010;
    tick(10);

    for (int i = 0; i < 8; i++) begin
      old_sw = sw_lvl;
      SW_raw = vecs[i].sw;
      DHR_in = vecs[i].dhr;
      DLR_in = vecs[i].dlr;
      exp_lo = vecs[i].seg_lo;
      exp_hi = vecs[i].seg_hi;
      push(5, old_sw, 4'h0, "tbl_hold");
      push(6, vecs[i].sw, 4'h0, "tbl_sw");
      sw_lvl = vecs[i].sw;
      tick(8);
    end
    DHR_in = 4'hA;
    DLR_in = 4'h1;
    exp_lo = 7'h79;
    exp_hi = 7'h08;

    // Three-cycle glitch on a switch is filtered out
    SW_raw = sw_lvl ^ 4'b0001;
    push(5, sw_lvl, 4'h0, "glitch_5");
    push(6, sw_lvl, 4'h0, "glitch_6");
    push(8, sw_lvl, 4'h0, "glitch_8");
    push(10, sw_lvl, 4'h0, "glitch_10");
    tick(3);
    SW_raw = sw_lvl;
    tick(10);

    // Bouncing button: short burst, gap, then steady press
    PB_raw = 4'b0100;
    tick(2);
    PB_raw = 4'b0000;
    tick(2);
    PB_raw = 4'b0100;
    push(6, sw_lvl, 4'h0, "pb2_early");
    push(7, sw_lvl, 4'b0100, "pb2_pulse");
    push(8, sw_lvl, 4'h0, "pb2_after");
    tick(20);
    PB_raw = 4'b0000;
    tick(10);

    // Two buttons pressed together
    PB_raw = 4'b1001;
    push(7, sw_lvl, 4'b1001, "pb_simul");
    push(8, sw_lvl, 4'h0, "pb_simul_held");
    tick(15);
    PB_raw = 4'b0000;
    tick(10);

    // Reset in the middle of a debounce, button held through release
    PB_raw = 4'b0001;
    tick(3);
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    push(6, sw_lvl, 4'h0, "pb0_rst_early");
    push(7, sw_lvl, 4'b0001, "pb0_rst_pulse");
    push(8, sw_lvl, 4'h0, "pb0_rst_after");
    tick(12);
    PB_raw = 4'b0000;
    tick(10);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d want=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
